// File: rtl/dcache_pkg.sv
// Shared geometry and state encoding for the direct-mapped write-back L1 dcache.
package dcache_pkg;
  localparam int LINES  = 32;
  localparam int LINE_W = 256;
  localparam int WORD_W = 32;
  localparam int WORDS  = LINE_W / WORD_W;
  localparam int IDX_W  = 5;
  localparam int OFF_W  = 5;
  localparam int WSEL_W = 3;
  localparam int TAG_W  = 32 - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE,
    S_REFILL
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;
endpackage

// File: rtl/dcache_tag_array.sv
// Per-line valid/dirty/tag store: combinational read, synchronous write, async clear of valid/dirty.
module dcache_tag_array
  import dcache_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx,
  output tag_entry_t       rd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  tag_entry_t       wr_entry
);
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q [LINES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_entry.valid;
      dirty_q[wr_idx] <= wr_entry.dirty;
    end
  end

  // Tags need no reset: they are meaningless while valid is clear.
  always_ff @(posedge clk_i) begin
    if (wr_en) tag_q[wr_idx] <= wr_entry.tag;
  end

  assign rd_entry.valid = valid_q[rd_idx];
  assign rd_entry.dirty = dirty_q[rd_idx];
  assign rd_entry.tag   = tag_q[rd_idx];
endmodule

// File: rtl/dcache_controller.sv
// L1 dcache controller: hit path to the data SRAM, miss sequencing (write-back, allocate, refill).
module dcache_controller
  import dcache_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         sram_enable_o,
  output logic         sram_write_o,
  output logic [4:0]   sram_addr_o,
  output logic [255:0] sram_data_o,
  input  logic [255:0] sram_data_i,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
);
  state_e state_q, state_d;

  logic [TAG_W-1:0]  addr_tag;
  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] word;
  logic              unused_addr;
  logic              req, hit;
  tag_entry_t        rd_entry, wr_entry;
  logic              tag_wr;

  logic [WORDS-1:0][WORD_W-1:0] rd_words, wr_words;

  assign addr_tag    = cpu_addr_i[31:IDX_W+OFF_W];
  assign idx         = cpu_addr_i[IDX_W+OFF_W-1:OFF_W];
  assign word        = cpu_addr_i[OFF_W-1:2];
  assign unused_addr = ^cpu_addr_i[1:0];

  // Gating with reset keeps every output at zero while rst_i is held.
  assign req = cpu_req_i & ~rst_i;
  assign hit = req & rd_entry.valid & (rd_entry.tag == addr_tag);

  dcache_tag_array u_tags (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_idx   (idx),
    .rd_entry (rd_entry),
    .wr_en    (tag_wr),
    .wr_idx   (idx),
    .wr_entry (wr_entry)
  );

  assign rd_words = sram_data_i;
  always_comb begin
    wr_words       = rd_words;
    wr_words[word] = cpu_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    cpu_data_o    = '0;
    cpu_stall_o   = 1'b0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_addr_o   = '0;
    sram_data_o   = '0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    tag_wr        = 1'b0;
    wr_entry      = '{valid: 1'b0, dirty: 1'b0, tag: '0};
    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          sram_enable_o = 1'b1;
          sram_addr_o   = idx;
          if (cpu_write_i) begin
            sram_write_o = 1'b1;
            sram_data_o  = wr_words;
            tag_wr       = 1'b1;
            wr_entry     = '{valid: 1'b1, dirty: 1'b1, tag: addr_tag};
          end else begin
            cpu_data_o = rd_words[word];
          end
        end else if (req) begin
          cpu_stall_o = 1'b1;
          state_d     = (rd_entry.valid && rd_entry.dirty) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        cpu_stall_o   = 1'b1;
        sram_enable_o = 1'b1;
        sram_addr_o   = idx;
        mem_enable_o  = 1'b1;
        mem_write_o   = 1'b1;
        mem_addr_o    = {rd_entry.tag, idx, OFF_W'(0)};
        mem_data_o    = sram_data_i;
        if (mem_ack_i) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {addr_tag, idx, OFF_W'(0)};
        sram_addr_o  = idx;
        if (mem_ack_i) begin
          sram_enable_o = 1'b1;
          sram_write_o  = 1'b1;
          sram_data_o   = mem_data_i;
          tag_wr        = 1'b1;
          wr_entry      = '{valid: 1'b1, dirty: 1'b0, tag: addr_tag};
          state_d       = S_REFILL;
        end
      end
      S_REFILL: begin
        cpu_stall_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating counters; only IDLE lookups are counted so a miss counts once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (state_q == S_IDLE && req) begin
      if (hit && hit_cnt_o != 32'hFFFF_FFFF)   hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (!hit && miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller with a behavioural data SRAM and off-chip memory.
module tb_dcache_controller;
  logic         clk_i = 0, rst_i = 1;
  logic         cpu_req_i = 0, cpu_write_i = 0;
  logic [31:0]  cpu_addr_i = 0, cpu_data_i = 0, cpu_data_o;
  logic         cpu_stall_o, sram_enable_o, sram_write_o;
  logic [4:0]   sram_addr_o;
  logic [255:0] sram_data_o, sram_data_i, mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o, hit_cnt_o, miss_cnt_o;
  logic         mdl_ack = 0, stray_ack = 0, mem_ack_i;

  assign mem_ack_i = mdl_ack | stray_ack;

  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o), .sram_addr_o(sram_addr_o),
    .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, passed = 0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Data SRAM: combinational read, synchronous write.
  logic [255:0] sram [32];
  initial for (int i = 0; i < 32; i++) sram[i] = '0;
  assign sram_data_i = sram[sram_addr_o];
  always @(posedge clk_i) if (sram_enable_o && sram_write_o) sram[sram_addr_o] <= sram_data_o;

  // Off-chip memory: unwritten lines hold a fixed address-derived pattern.
  logic [255:0] store [logic [31:0]];

  function automatic logic [31:0] pat(logic [31:0] a, int w);
    logic [31:0] wv;
    wv = w;
    return (a & ~32'h1F) ^ (wv << 24) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [255:0] line_of(logic [31:0] a);
    logic [255:0] l;
    if (store.exists(a)) return store[a];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat(a, w);
    return l;
  endfunction

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] line;
  } mem_txn_t;

  mem_txn_t    exp_mem [$];
  logic [31:0] exp_load [$];
  int          ack_dly = 1;
  int          mcnt = 0;
  bit          wr_seen = 0;

  // Memory model: ack on the ack_dly-th cycle of a held request, checking it against the scoreboard.
  always @(negedge clk_i) begin
    mdl_ack = 0;
    if (mem_enable_o && mem_write_o) wr_seen = 1;
    if (rst_i || !mem_enable_o) mcnt = 0;
    else begin
      mcnt++;
      if (mcnt >= ack_dly) begin
        mem_txn_t e;
        mcnt = 0;
        mdl_ack = 1;
        if (exp_mem.size() == 0) begin
          total++;
          $display("FAIL mem_unexpected: got request addr %0h wr %0b expected none", mem_addr_o, mem_write_o);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_write", mem_write_o, e.wr);
          chk("mem_addr", mem_addr_o, e.addr);
          if (e.wr) begin
            chk("wb_line", mem_data_o, e.line);
            store[mem_addr_o] = mem_data_o;
          end else mem_data_i = line_of(mem_addr_o);
        end
      end
    end
  end

  // Load monitor: every unstalled load is checked against the queued expectation.
  always @(negedge clk_i) begin
    if (!rst_i && cpu_req_i && !cpu_stall_o && !cpu_write_i) begin
      if (exp_load.size() == 0) begin
        total++;
        $display("FAIL load_unexpected: got %0h expected no load", cpu_data_o);
      end else chk("load_data", cpu_data_o, exp_load.pop_front());
    end
  end

  task automatic access(bit wr, logic [31:0] a, logic [31:0] d, output int stalls);
    @(posedge clk_i); #1;
    cpu_req_i = 1; cpu_write_i = wr; cpu_addr_i = a; cpu_data_i = d;
    stalls = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk_i);
      if (!cpu_stall_o) return;
      stalls++;
    end
    total++;
    $display("FAIL access_timeout: got stall after %0d cycles expected release", stalls);
  endtask

  task automatic idle();
    @(posedge clk_i); #1;
    cpu_req_i = 0; cpu_write_i = 0;
  endtask

  task automatic load(logic [31:0] a, logic [31:0] exp, output int stalls);
    exp_load.push_back(exp);
    access(0, a, 32'h0, stalls);
  endtask

  initial begin
    int st, sum;
    logic [255:0] wb;
    #12;
    // Reset state
    chk("rst_stall", cpu_stall_o, 0);
    chk("rst_mem_en", mem_enable_o, 0);
    chk("rst_sram_en", sram_enable_o, 0);
    chk("rst_hits", hit_cnt_o, 0);
    chk("rst_miss", miss_cnt_o, 0);
    @(negedge clk_i); rst_i = 0;

    // 1: cold load miss, ack on 9th request cycle -> 11 stall cycles
    ack_dly = 9;
    exp_mem.push_back('{0, 32'h400, '0});
    load(32'h400, pat(32'h400, 0), st);
    chk("t1_stalls", st, 11);
    idle();
    chk("t1_miss", miss_cnt_o, 1);
    chk("t1_hits", hit_cnt_o, 1);

    // 2: store hit then load hit
    access(1, 32'h404, 32'hDEADBEEF, st);
    chk("t2_store_stalls", st, 0);
    load(32'h404, 32'hDEADBEEF, st);
    chk("t2_load_stalls", st, 0);
    idle();
    chk("t2_hits", hit_cnt_o, 3);

    // 3: dirty victim -> write-back of 0x400 then allocate 0x800
    ack_dly = 3;
    wb = line_of(32'h400);
    wb[63:32] = 32'hDEADBEEF;
    exp_mem.push_back('{1, 32'h400, wb});
    exp_mem.push_back('{0, 32'h800, '0});
    load(32'h800, pat(32'h800, 0), st);
    chk("t3_stalls", st, 8);
    idle();
    chk("t3_miss", miss_cnt_o, 2);
    chk("t3_hits", hit_cnt_o, 4);

    // 4: clean victim -> no write-back
    wr_seen = 0;
    exp_mem.push_back('{0, 32'hC00, '0});
    load(32'hC0C, pat(32'hC00, 3), st);
    chk("t4_stalls", st, 5);
    chk("t4_no_wb", wr_seen, 0);
    idle();
    chk("t4_miss", miss_cnt_o, 3);
    chk("t4_hits", hit_cnt_o, 5);

    // 5: reset in the middle of an allocate
    ack_dly = 20;
    @(posedge clk_i); #1;
    cpu_req_i = 1; cpu_addr_i = 32'h1000;
    repeat (3) @(negedge clk_i);
    chk("t5_mem_en_before", mem_enable_o, 1);
    #2 rst_i = 1;
    #1;
    chk("t5_mem_en_async", mem_enable_o, 0);
    chk("t5_stall_rst", cpu_stall_o, 0);
    chk("t5_miss_rst", miss_cnt_o, 0);
    cpu_req_i = 0;
    @(negedge clk_i); rst_i = 0;
    ack_dly = 2;
    exp_mem.push_back('{0, 32'hC00, '0});
    load(32'hC00, pat(32'hC00, 0), st);
    chk("t5_miss_after_rst", st, 4);
    idle();
    chk("t5_miss", miss_cnt_o, 1);
    chk("t5_hits", hit_cnt_o, 1);

    // 6: fill 32 lines, then 32 back-to-back hits with stray acks
    ack_dly = 1;
    sum = 0;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] a;
      a = 32'h2000 | (i << 5) | ((i % 8) << 2);
      exp_mem.push_back('{0, a & ~32'h1F, '0});
      load(a, pat(a, i % 8), st);
      sum += st;
    end
    chk("t6_fill_stalls", sum, 32 * 3);
    sum = 0;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] a;
      a = 32'h2000 | (i << 5) | (((i + 5) % 8) << 2);
      stray_ack = i[0];
      load(a, pat(a, (i + 5) % 8), st);
      sum += st;
    end
    stray_ack = 0;
    chk("t6_hit_stalls", sum, 0);
    idle();
    chk("t6_hits", hit_cnt_o, 65);
    chk("t6_miss", miss_cnt_o, 33);
    chk("load_q_empty", exp_load.size(), 0);
    chk("mem_q_empty", exp_mem.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
